// File: rtl/uart_tx.sv
// uart_tx: drains an upstream byte fifo onto a serial line as 8N1/8N2 frames.
// Define UART_TX_PARITY_EN to insert an even parity bit after data bit 7.
module uart_tx #(
  parameter int DIVISOR   = 104,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_available,
  input  logic [7:0] read_data,
  output logic       read_strobe,
  output logic       tx,
  output logic       busy
);

  localparam int TW = $clog2(DIVISOR);
  localparam logic [TW-1:0] TLOAD = TW'(DIVISOR - 1);
  localparam logic SLAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic bit_end;
  logic last_stop;

  assign bit_end   = (timer_q == '0);
  assign last_stop = (state_q == S_STOP) && bit_end
                   && (stop_q == SLAST);

  // Pop only when idle or in the very last stop-bit cycle.
  assign read_strobe = data_available & ~reset
                     & ((state_q == S_IDLE) | last_stop);

  assign tx   = tx_q;
  assign busy = busy_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (!bit_end) begin
      timer_d = timer_q - 1'b1;
    end
    if (read_strobe) begin
      state_d = S_START;
      timer_d = TLOAD;
      shift_d = read_data;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^read_data;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          tx_d = 1'b1;
        end
        S_START: begin
          if (bit_end) begin
            state_d = S_DATA;
            timer_d = TLOAD;
            bit_d   = 3'd0;
            tx_d    = shift_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            timer_d = TLOAD;
            shift_d = {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_d = S_PARITY;
              tx_d    = par_q;
`else
              state_d = S_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
`endif
            end else begin
              bit_d = bit_q + 3'd1;
              tx_d  = shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_d = S_STOP;
            timer_d = TLOAD;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (stop_q != SLAST) begin
              stop_d  = stop_q + 1'b1;
              timer_d = TLOAD;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx, three instances with
// different DIVISOR/STOP_BITS sharing one clock and reset.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL0 = (9 + PB + 1) * 4;
  localparam int FL1 = (9 + PB + 2) * 4;
  localparam int FL2 = (9 + PB + 1) * 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] da_w = '0;
  logic [7:0] rd_w [3];
  wire  [2:0] stb_w;
  wire  [2:0] tx_w;
  wire  [2:0] busy_w;

  uart_tx #(.DIVISOR(4), .STOP_BITS(1)) u_d0 (
    .clk(clk), .reset(reset),
    .data_available(da_w[0]), .read_data(rd_w[0]),
    .read_strobe(stb_w[0]), .tx(tx_w[0]), .busy(busy_w[0])
  );
  uart_tx #(.DIVISOR(4), .STOP_BITS(2)) u_d1 (
    .clk(clk), .reset(reset),
    .data_available(da_w[1]), .read_data(rd_w[1]),
    .read_strobe(stb_w[1]), .tx(tx_w[1]), .busy(busy_w[1])
  );
  uart_tx #(.DIVISOR(2), .STOP_BITS(1)) u_d2 (
    .clk(clk), .reset(reset),
    .data_available(da_w[2]), .read_data(rd_w[2]),
    .read_strobe(stb_w[2]), .tx(tx_w[2]), .busy(busy_w[2])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] fifo_mem [3][1024];
  logic [7:0] exp_mem  [3][1024];
  int fh [3];
  int ft [3];
  int eh [3];
  int et [3];
  int sent [3];
  int nstb [3];
  int nfr [3];
  int last_st [3];
  int prev_st [3];
  bit [2:0] pend = '0;
  bit [2:0] hold = '0;
  bit hold_en = 1'b0;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic send(input int k, input logic [7:0] b);
    fifo_mem[k][ft[k] % 1024] = b;
    ft[k]++;
    exp_mem[k][et[k] % 1024] = b;
    et[k]++;
    sent[k]++;
  endtask

  // Line level of bit j of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (PB == 1 && j == 9) return ^b;
    return 1'b1;
  endfunction

  // Fifo model: pops on the edge after a sampled strobe.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (pend[k]) fh[k]++;
      hold[k] = hold_en && ($urandom_range(3) == 0);
      da_w[k] = (ft[k] != fh[k]) && !hold[k];
      rd_w[k] = (ft[k] != fh[k]) ? fifo_mem[k][fh[k] % 1024] : 8'h00;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      pend[k] = stb_w[k];
      if (stb_w[k]) nstb[k]++;
    end
  end

  task automatic monitor(input int k, input int div, input int sb);
    int fl;
    int nerr;
    bit ab;
    logic [7:0] b;
    fl = (9 + PB + sb) * div;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && tx_w[k] == 1'b0) begin
        prev_st[k] = last_st[k];
        last_st[k] = cyc;
        nerr = 0;
        ab = 1'b0;
        chk(eh[k] != et[k], $sformatf("frame_expected%0d", k),
            et[k] - eh[k], 1);
        b = exp_mem[k][eh[k] % 1024];
        if (eh[k] != et[k]) eh[k]++;
        for (int i = 0; i < fl; i++) begin
          if (i != 0) begin
            @(negedge clk);
            #2;
          end
          if (reset) begin
            ab = 1'b1;
            break;
          end
          if (tx_w[k] !== exp_bit(b, i / div)) nerr++;
          if (busy_w[k] !== 1'b1) nerr++;
          if (stb_w[k] && i != fl - 1) nerr++;
        end
        if (!ab) begin
          chk(nerr == 0, $sformatf("frame%0d_%02h", k, b), nerr, 0);
          nfr[k]++;
        end
      end
    end
  endtask

  task automatic measure_busy(input int k, output int n);
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #3;
      if (busy_w[k]) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic wait_idle(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #3;
      if (ft[0] == fh[0] && ft[1] == fh[1] && ft[2] == fh[2]
          && busy_w == 3'b000 && pend == 3'b000) begin
        done = 1'b1;
        break;
      end
    end
    chk(done, "wait_idle", 0, 1);
  endtask

  initial begin
    int n;
    int s0;
    int err;
    int k;
    fork
      monitor(0, 4, 1);
      monitor(1, 4, 2);
      monitor(2, 2, 1);
    join_none

    // Reset held with a byte pending.
    send(0, 8'h55);
    repeat (4) begin
      @(negedge clk);
      #3;
      chk(stb_w[0] == 1'b0, "rst_strobe", stb_w[0], 0);
      chk(tx_w[0] == 1'b1, "rst_tx", tx_w[0], 1);
      chk(busy_w[0] == 1'b0, "rst_busy", busy_w[0], 0);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    #3;
    chk(stb_w[0] == 1'b1, "first_strobe", stb_w[0], 1);
    measure_busy(0, n);
    chk(n == FL0, "busy_len_55", n, FL0);
    chk(nstb[0] == 1, "strobes_55", nstb[0], 1);

    // Two queued bytes go out back to back.
    @(posedge clk);
    #2;
    s0 = nstb[0];
    send(0, 8'hA5);
    send(0, 8'h3C);
    measure_busy(0, n);
    chk(n == 2 * FL0, "busy_len_pair", n, 2 * FL0);
    chk(nstb[0] - s0 == 2, "strobes_pair", nstb[0] - s0, 2);
    chk(last_st[0] - prev_st[0] == FL0, "start_gap",
        last_st[0] - prev_st[0], FL0);
    repeat (3) @(negedge clk);
    #3;
    chk(tx_w[0] == 1'b1 && busy_w[0] == 1'b0, "idle_after_pair",
        {tx_w[0], busy_w[0]}, 2);

    // Parity-sensitive bytes.
    @(posedge clk);
    #2;
    send(0, 8'h07);
    measure_busy(0, n);
    chk(n == FL0, "busy_len_07", n, FL0);
    @(posedge clk);
    #2;
    send(0, 8'h03);
    measure_busy(0, n);
    chk(n == FL0, "busy_len_03", n, FL0);

    // Two stop bits.
    @(posedge clk);
    #2;
    send(1, 8'hFF);
    measure_busy(1, n);
    chk(n == FL1, "busy_len_ff_2stop", n, FL1);
    chk(tx_w[1] == 1'b1, "idle_after_2stop", tx_w[1], 1);

    // Minimum divisor, three queued bytes.
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) send(2, 8'($urandom));
    measure_busy(2, n);
    chk(n == 3 * FL2, "busy_len_div2", n, 3 * FL2);

    // Reset during data bit 3 of 0x81.
    @(posedge clk);
    #2;
    send(0, 8'h81);
    s0 = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #3;
      if (stb_w[0]) begin
        s0 = 1;
        break;
      end
    end
    chk(s0 == 1, "strobe_81", s0, 1);
    repeat (17) @(negedge clk);
    #3;
    chk(tx_w[0] == 1'b0, "pre_rst_bit3", tx_w[0], 0);
    reset = 1'b1;
    #1;
    chk(tx_w[0] == 1'b1, "async_tx", tx_w[0], 1);
    chk(busy_w[0] == 1'b0, "async_busy", busy_w[0], 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    s0 = nstb[0];
    err = 0;
    repeat (60) begin
      @(negedge clk);
      #3;
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || stb_w[0] !== 1'b0)
        err++;
    end
    chk(err == 0, "idle_after_rst", err, 0);
    chk(nstb[0] == s0, "no_repop", nstb[0] - s0, 0);

    // Random traffic with data_available dropouts.
    hold_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(4) == 0) begin
        k = ($urandom_range(1) == 0) ? 0 : 2;
        send(k, 8'($urandom));
      end
    end
    wait_idle(20000);
    hold_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      chk(eh[j] == et[j], $sformatf("exp_drained%0d", j),
          et[j] - eh[j], 0);
      chk(nstb[j] == sent[j], $sformatf("strobes_total%0d", j),
          nstb[j], sent[j]);
      chk(nfr[j] == sent[j] - (j == 0 ? 1 : 0),
          $sformatf("frames_total%0d", j),
          nfr[j], sent[j] - (j == 0 ? 1 : 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=%0d required=0", cyc);
    $fatal(1, "watchdog");
  end

endmodule
